// File: rtl/menlo_audio_sample_bridge.sv
// rtl/menlo_audio_sample_bridge.sv - Gigatron audio sample to 16-bit PCM bridge into the I2S sclk domain
module menlo_audio_sample_bridge #(
  parameter int IN_WIDTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                sclk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] audio_sample,
  input  logic                sample_strobe,
  input  logic [1:0]          volume,
  input  logic                mute,
  input  logic                lrclk,
  output logic [15:0]         audio_out,
  output logic                frame_update,
  output logic [7:0]          overrun_count
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  localparam logic [IN_WIDTH-1:0] MSB_MASK = {1'b1, {(IN_WIDTH-1){1'b0}}};

  // ---------------- reset synchronizers ----------------
  logic [1:0] rst_clk_ff;
  logic [1:0] rst_sclk_ff;
  logic       rst_n_clk;
  logic       rst_n_sclk;

  // clk-domain reset: asserts immediately, releases two clk edges later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_clk_ff <= 2'b00;
    else          rst_clk_ff <= {rst_clk_ff[0], 1'b1};
  end

  // sclk-domain reset: asserts immediately, releases two sclk edges later
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) rst_sclk_ff <= 2'b00;
    else          rst_sclk_ff <= {rst_sclk_ff[0], 1'b1};
  end

  assign rst_n_clk  = rst_clk_ff[1];
  assign rst_n_sclk = rst_sclk_ff[1];

  // ---------------- conversion (clk domain) ----------------
  // Flipping the MSB turns offset-binary into two's complement; the
  // arithmetic shift then attenuates by 6 dB per volume step below 3.
  logic signed [15:0] s_ext;
  logic signed [15:0] conv_shift;
  logic        [15:0] conv;

  assign s_ext      = {audio_sample ^ MSB_MASK, {(16-IN_WIDTH){1'b0}}};
  assign conv_shift = s_ext >>> (2'd3 - volume);
  assign conv       = mute ? 16'h0000 : conv_shift;

  // ---------------- source side (clk domain) ----------------
  state_t                 state, state_nx;
  logic [15:0]            hold_reg, hold_nx;
  logic [15:0]            pend_reg, pend_nx;
  logic                   pending_valid, pending_nx;
  logic                   req, req_nx;
  logic [7:0]             overrun_nx;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_seen;
  logic                   ack_edge;
  logic                   ack;

  assign ack_edge = ack_sync[SYNC_STAGES-1] ^ ack_seen;

  // bring the destination's ack toggle back into clk and remember the last seen level
  always_ff @(posedge clk or negedge rst_n_clk) begin
    if (!rst_n_clk) begin
      ack_sync <= '0;
      ack_seen <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
      ack_seen <= ack_sync[SYNC_STAGES-1];
    end
  end

  // source FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n_clk) begin
    if (!rst_n_clk) begin
      state         <= IDLE;
      hold_reg      <= '0;
      pend_reg      <= '0;
      pending_valid <= 1'b0;
      req           <= 1'b0;
      overrun_count <= '0;
    end else begin
      state         <= state_nx;
      hold_reg      <= hold_nx;
      pend_reg      <= pend_nx;
      pending_valid <= pending_nx;
      req           <= req_nx;
      overrun_count <= overrun_nx;
    end
  end

  // next-state: launch a sample, park one extra while busy, keep only the newest
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_reg;
    pend_nx    = pend_reg;
    pending_nx = pending_valid;
    req_nx     = req;
    overrun_nx = overrun_count;
    case (state)
      IDLE: begin
        if (sample_strobe) begin
          hold_nx  = conv;
          req_nx   = ~req;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_edge && sample_strobe) begin
          hold_nx    = conv;
          req_nx     = ~req;
          pending_nx = 1'b0;
          if (pending_valid && overrun_count != 8'hFF) overrun_nx = overrun_count + 8'd1;
        end else if (ack_edge) begin
          if (pending_valid) begin
            hold_nx    = pend_reg;
            req_nx     = ~req;
            pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else if (sample_strobe) begin
          pend_nx    = conv;
          pending_nx = 1'b1;
          if (pending_valid && overrun_count != 8'hFF) overrun_nx = overrun_count + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- destination side (sclk domain) ----------------
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_edge;
  logic [15:0]            stage_reg;
  logic                   lrclk_d;
  logic                   frame_boundary;

  assign req_edge       = req_sync[SYNC_STAGES-1] ^ ack;
  assign frame_boundary = !lrclk_d && lrclk;

  // capture hold_reg on a new req toggle and answer by mirroring req onto ack
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      req_sync  <= '0;
      ack       <= 1'b0;
      stage_reg <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req};
      if (req_edge) begin
        stage_reg <= hold_reg;
        ack       <= req_sync[SYNC_STAGES-1];
      end
    end
  end

  // reload audio_out only on the lrclk rising edge so a frame never changes mid-word
  always_ff @(posedge sclk or negedge rst_n_sclk) begin
    if (!rst_n_sclk) begin
      lrclk_d      <= 1'b0;
      audio_out    <= '0;
      frame_update <= 1'b0;
    end else begin
      lrclk_d      <= lrclk;
      frame_update <= frame_boundary;
      if (frame_boundary) audio_out <= stage_reg;
    end
  end

endmodule

// File: tb/tb_menlo_audio_sample_bridge.sv
// tb/tb_menlo_audio_sample_bridge.sv - scoreboard bench for menlo_audio_sample_bridge
module tb_menlo_audio_sample_bridge;

  localparam int IN_WIDTH    = 4;
  localparam int SYNC_STAGES = 2;

  logic                clk = 1'b0;
  logic                sclk = 1'b0;
  logic                reset_n = 1'b0;
  logic [IN_WIDTH-1:0] audio_sample = '0;
  logic                sample_strobe = 1'b0;
  logic [1:0]          volume = 2'd3;
  logic                mute = 1'b0;
  logic                lrclk = 1'b0;
  logic [15:0]         audio_out;
  logic                frame_update;
  logic [7:0]          overrun_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_out = 16'h0000;
  logic        mon_en = 1'b0;
  logic [15:0] mon_prev = 16'h0000;
  int          lr_cnt = 0;

  menlo_audio_sample_bridge #(
    .IN_WIDTH(IN_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .sclk(sclk),
    .reset_n(reset_n),
    .audio_sample(audio_sample),
    .sample_strobe(sample_strobe),
    .volume(volume),
    .mute(mute),
    .lrclk(lrclk),
    .audio_out(audio_out),
    .frame_update(frame_update),
    .overrun_count(overrun_count)
  );

  always #80 clk = ~clk;
  always #326 sclk = ~sclk;

  // serializer word clock: 16 sclk per half, changes on falling sclk
  always @(negedge sclk) begin
    if (lr_cnt == 15) begin
      lr_cnt <= 0;
      lrclk  <= ~lrclk;
    end else begin
      lr_cnt <= lr_cnt + 1;
    end
  end

  // audio_out may only move together with a frame_update pulse
  always @(negedge sclk) begin
    if (!mon_en) begin
      mon_prev <= audio_out;
    end else if (audio_out !== mon_prev) begin
      vectors++;
      assert (frame_update === 1'b1) else begin
        miscompares++;
        $display("FAIL midframe_change observed_update=%b expected_update=1 out=%h", frame_update, audio_out);
        $error("audio_out changed without frame_update");
      end
      mon_prev <= audio_out;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  // reference conversion: signed offset times 4096, divided by the attenuation
  function automatic logic [15:0] model(int v, int vol, bit m);
    int val;
    if (m) return 16'h0000;
    val = ((v - 8) * 4096) / (1 << (3 - vol));
    return val[15:0];
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic strobe(int v, bit push);
    @(negedge clk);
    audio_sample  = v[IN_WIDTH-1:0];
    sample_strobe = 1'b1;
    if (push) exp_q.push_back(model(v, volume, mute));
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  // wait for the next visible audio_out change and compare against the scoreboard head
  task automatic check_next(string tag);
    bit got = 0;
    logic [15:0] exp;
    for (int n = 0; n < 200; n++) begin
      @(negedge sclk);
      if (frame_update === 1'b1 && audio_out !== cur_out) begin
        got = 1;
        break;
      end
    end
    if (!got || exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s observed=no_update_or_empty_queue expected=update", tag);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, audio_out, exp);
      cur_out = audio_out;
    end
  endtask

  task automatic wait_frame(string tag);
    bit got = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge sclk);
      if (frame_update === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s observed=no_frame_update expected=frame_update", tag);
    end
  endtask

  initial begin
    logic [15:0] held;
    int period;

    // reset state
    repeat (4) @(negedge sclk);
    chk("reset_audio_out", audio_out, 16'h0000);
    chk("reset_frame_update", {15'd0, frame_update}, 16'h0000);
    chk("reset_overrun", {8'd0, overrun_count}, 16'h0000);
    reset_n = 1'b1;
    repeat (6) @(negedge sclk);
    mon_en = 1'b1;

    // idle running lrclk: zero output, frame every 32 sclk
    wait_frame("first_frame");
    period = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge sclk);
      period++;
      if (frame_update === 1'b1) break;
    end
    chk("frame_period", period[15:0], 16'd32);
    chk("idle_audio_out", audio_out, 16'h0000);

    // full scale samples
    volume = 2'd3;
    strobe(15, 1); check_next("vol3_s15");
    repeat (200) @(negedge clk);
    strobe(0, 1);  check_next("vol3_s0");
    repeat (200) @(negedge clk);
    strobe(8, 1);  check_next("vol3_s8");

    // volume steps and mute
    @(negedge clk); volume = 2'd2;
    strobe(15, 1); check_next("vol2_s15");
    @(negedge clk); volume = 2'd0;
    strobe(0, 1);  check_next("vol0_s0");
    @(negedge clk); mute = 1'b1; volume = 2'd3;
    strobe(15, 1); check_next("mute_s15");
    @(negedge clk); mute = 1'b0;

    // three consecutive strobes: first equals current output, middle dropped, last wins
    @(negedge clk);
    audio_sample = 4'd8;  sample_strobe = 1'b1;
    @(negedge clk);
    audio_sample = 4'd2;
    @(negedge clk);
    audio_sample = 4'd5;
    exp_q.push_back(model(5, 3, 0));
    @(negedge clk);
    sample_strobe = 1'b0;
    check_next("burst_last");
    @(negedge clk);
    chk("burst_overrun", {8'd0, overrun_count}, 16'd1);

    // new sample arrives early in a frame: output must hold for the whole frame
    wait_frame("midframe_start");
    held = audio_out;
    strobe(10, 1);
    for (int n = 0; n < 28; n++) begin
      @(negedge sclk);
      chk("midframe_hold", audio_out, held);
    end
    check_next("midframe_next");

    // reset with a handshake outstanding
    strobe(7, 0);
    @(negedge clk);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_audio_out", audio_out, 16'h0000);
    chk("rst_frame_update", {15'd0, frame_update}, 16'h0000);
    chk("rst_overrun", {8'd0, overrun_count}, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cur_out = 16'h0000;
    repeat (10) @(negedge sclk);
    mon_en = 1'b1;
    strobe(12, 1);
    check_next("post_reset_s12");
    @(negedge clk);
    chk("post_reset_overrun", {8'd0, overrun_count}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
